// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Package : pipeline_ctrl_pkg
// | Shared state encodings and defaults for the pipeline control unit.
// | Rev 1.0 : initial release
// +-----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } pcu_state_e;

    localparam int DRAIN_CYCLES_DEF = 3;

endpackage : pipeline_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_control_unit_hazard_detect.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module  : hazard_detect
// | Combinational load-use hazard between the ID/EX load and the ID instruction.
// | Rev 1.0 : initial release
// +-----------------------------------------------------------------------------
module hazard_detect #(
    parameter int NB_REG = 5
) (
    input  logic              idex_mem_read_i,
    input  logic [NB_REG-1:0] idex_rw_i,
    input  logic [NB_REG-1:0] ifid_rs_i,
    input  logic [NB_REG-1:0] ifid_rt_i,
    input  logic              ifid_uses_rt_i,
    output logic              hazard_o
);

    // r0 is hardwired to zero, so a load into it never creates a dependency
    assign hazard_o = idex_mem_read_i
                    & (idex_rw_i != '0)
                    & ((idex_rw_i == ifid_rs_i)
                       | (ifid_uses_rt_i & (idex_rw_i == ifid_rt_i)));

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipeline_control_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module  : pipeline_control_unit
// | Pipeline enable/flush sequencing: load-use stall, branch flush, HALT drain,
// | debug single-step, plus cycle and stall statistics.
// | Rev 1.0 : initial release
// +-----------------------------------------------------------------------------
module pipeline_control_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int NB_REG       = 5,
    parameter int NB_CNT       = 32,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic              clock,
    input  logic              reset_i,
    input  logic              debug_mode_i,
    input  logic              step_i,
    input  logic              idex_mem_read_i,
    input  logic [NB_REG-1:0] idex_rw_i,
    input  logic [NB_REG-1:0] ifid_rs_i,
    input  logic [NB_REG-1:0] ifid_rt_i,
    input  logic              ifid_uses_rt_i,
    input  logic              branch_taken_i,
    input  logic              halt_id_i,
    output logic              en_pc_o,
    output logic              en_ifid_o,
    output logic              flush_ifid_o,
    output logic              en_idex_o,
    output logic              flush_idex_o,
    output logic              en_back_o,
    output logic              halted_o,
    output logic [1:0]        state_o,
    output logic [NB_CNT-1:0] cycle_count_o,
    output logic [NB_CNT-1:0] stall_count_o
);

    localparam int                NB_DRN       = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [NB_DRN-1:0] c_drain_load = NB_DRN'(DRAIN_CYCLES);
    localparam logic [NB_DRN-1:0] c_drain_one  = NB_DRN'(1);
    localparam logic [NB_CNT-1:0] c_cnt_one    = NB_CNT'(1);

    pcu_state_e        r_state;
    logic [NB_DRN-1:0] r_drain_cnt;
    logic [NB_CNT-1:0] r_cycle_cnt;
    logic [NB_CNT-1:0] r_stall_cnt;

    logic w_adv;
    logic w_hazard;
    logic w_stall;
    logic w_halt_go;

    hazard_detect #(
        .NB_REG (NB_REG)
    ) u_hazard_detect (
        .idex_mem_read_i (idex_mem_read_i),
        .idex_rw_i       (idex_rw_i),
        .ifid_rs_i       (ifid_rs_i),
        .ifid_rt_i       (ifid_rt_i),
        .ifid_uses_rt_i  (ifid_uses_rt_i),
        .hazard_o        (w_hazard)
    );

    assign w_adv = ~debug_mode_i | step_i;

    // Gating with reset_i forces every control output low while reset is held
    always_comb begin
        en_pc_o      = 1'b0;
        en_ifid_o    = 1'b0;
        flush_ifid_o = 1'b0;
        en_idex_o    = 1'b0;
        flush_idex_o = 1'b0;
        en_back_o    = 1'b0;
        w_stall      = 1'b0;
        w_halt_go    = 1'b0;
        if (reset_i && w_adv) begin
            case (r_state)
                ST_RUN: begin
                    if (w_hazard) begin
                        en_idex_o    = 1'b1;
                        flush_idex_o = 1'b1;
                        en_back_o    = 1'b1;
                        w_stall      = 1'b1;
                    end else begin
                        en_pc_o   = 1'b1;
                        en_ifid_o = 1'b1;
                        en_idex_o = 1'b1;
                        en_back_o = 1'b1;
                        if (halt_id_i) begin
                            w_halt_go = 1'b1;
                        end else if (branch_taken_i) begin
                            flush_ifid_o = 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    en_idex_o    = 1'b1;
                    flush_idex_o = 1'b1;
                    en_back_o    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(negedge clock or negedge reset_i) begin
        if (!reset_i) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= '0;
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_adv) begin
                        if (r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + c_cnt_one;
                        if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + c_cnt_one;
                        if (w_halt_go) begin
                            r_state     <= ST_DRAIN;
                            r_drain_cnt <= c_drain_load;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_adv) begin
                        if (r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + c_cnt_one;
                        if (r_drain_cnt <= c_drain_one) begin
                            r_state     <= ST_HALTED;
                            r_drain_cnt <= '0;
                        end else begin
                            r_drain_cnt <= r_drain_cnt - c_drain_one;
                        end
                    end
                end
                ST_HALTED: ;
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign halted_o      = reset_i & (r_state == ST_HALTED);
    assign state_o       = r_state;
    assign cycle_count_o = r_cycle_cnt;
    assign stall_count_o = r_stall_cnt;

endmodule : pipeline_control_unit
`default_nettype wire

// File: tb/tb_pipeline_control_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | Module  : tb_pipeline_control_unit
// | Directed self-checking bench for pipeline_control_unit.
// | Rev 1.0 : initial release
// +-----------------------------------------------------------------------------
module tb_pipeline_control_unit;

    logic        clock;
    logic        reset_i;
    logic        rst_sat_n;
    logic        debug_mode_i;
    logic        step_i;
    logic        idex_mem_read_i;
    logic [4:0]  idex_rw_i;
    logic [4:0]  ifid_rs_i;
    logic [4:0]  ifid_rt_i;
    logic        ifid_uses_rt_i;
    logic        branch_taken_i;
    logic        halt_id_i;

    logic        en_pc_o, en_ifid_o, flush_ifid_o, en_idex_o, flush_idex_o, en_back_o, halted_o;
    logic [1:0]  state_o;
    logic [31:0] cycle_count_o, stall_count_o;

    logic        s_en_pc, s_en_ifid, s_flush_ifid, s_en_idex, s_flush_idex, s_en_back, s_halted;
    logic [1:0]  s_state;
    logic [3:0]  s_cycle, s_stall;

    int n_checks = 0;
    int n_errors = 0;

    pipeline_control_unit u_dut (
        .clock           (clock),
        .reset_i         (reset_i),
        .debug_mode_i    (debug_mode_i),
        .step_i          (step_i),
        .idex_mem_read_i (idex_mem_read_i),
        .idex_rw_i       (idex_rw_i),
        .ifid_rs_i       (ifid_rs_i),
        .ifid_rt_i       (ifid_rt_i),
        .ifid_uses_rt_i  (ifid_uses_rt_i),
        .branch_taken_i  (branch_taken_i),
        .halt_id_i       (halt_id_i),
        .en_pc_o         (en_pc_o),
        .en_ifid_o       (en_ifid_o),
        .flush_ifid_o    (flush_ifid_o),
        .en_idex_o       (en_idex_o),
        .flush_idex_o    (flush_idex_o),
        .en_back_o       (en_back_o),
        .halted_o        (halted_o),
        .state_o         (state_o),
        .cycle_count_o   (cycle_count_o),
        .stall_count_o   (stall_count_o)
    );

    // Narrow-counter instance, free-running with idle inputs, for saturation
    pipeline_control_unit #(.NB_CNT(4)) u_dut_sat (
        .clock           (clock),
        .reset_i         (rst_sat_n),
        .debug_mode_i    (1'b0),
        .step_i          (1'b0),
        .idex_mem_read_i (1'b0),
        .idex_rw_i       (5'd0),
        .ifid_rs_i       (5'd0),
        .ifid_rt_i       (5'd0),
        .ifid_uses_rt_i  (1'b0),
        .branch_taken_i  (1'b0),
        .halt_id_i       (1'b0),
        .en_pc_o         (s_en_pc),
        .en_ifid_o       (s_en_ifid),
        .flush_ifid_o    (s_flush_ifid),
        .en_idex_o       (s_en_idex),
        .flush_idex_o    (s_flush_idex),
        .en_back_o       (s_en_back),
        .halted_o        (s_halted),
        .state_o         (s_state),
        .cycle_count_o   (s_cycle),
        .stall_count_o   (s_stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Enable/flush vector ordered {en_pc, en_ifid, flush_ifid, en_idex, flush_idex, en_back}
    task automatic chk_en(input string tag, input logic [5:0] exp);
        chk(tag, {26'd0, en_pc_o, en_ifid_o, flush_ifid_o, en_idex_o, flush_idex_o, en_back_o},
            {26'd0, exp});
    endtask

    // Inputs change mid-cycle (posedge); the DUT registers on the following negedge
    task automatic drive(input logic dbg, input logic stp, input logic mr, input logic [4:0] rw,
                         input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                         input logic br, input logic hlt);
        @(posedge clock);
        debug_mode_i    = dbg;
        step_i          = stp;
        idex_mem_read_i = mr;
        idex_rw_i       = rw;
        ifid_rs_i       = rs;
        ifid_rt_i       = rt;
        ifid_uses_rt_i  = urt;
        branch_taken_i  = br;
        halt_id_i       = hlt;
        #1;
    endtask

    initial begin
        reset_i   = 1'b0;
        rst_sat_n = 1'b0;
        debug_mode_i = 1'b0; step_i = 1'b0; idex_mem_read_i = 1'b0;
        idex_rw_i = 5'd0; ifid_rs_i = 5'd0; ifid_rt_i = 5'd0;
        ifid_uses_rt_i = 1'b0; branch_taken_i = 1'b0; halt_id_i = 1'b0;
        #2;
        chk_en("rst_en", 6'b000000);
        chk("rst_halted", {31'd0, halted_o}, 32'd0);
        chk("rst_state", {30'd0, state_o}, 32'd0);
        chk("rst_cycle", cycle_count_o, 32'd0);
        chk("rst_stall", stall_count_o, 32'd0);
        #1;
        reset_i   = 1'b1;
        rst_sat_n = 1'b1;

        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        chk_en("idle", 6'b110101);
        chk("idle_cycle", cycle_count_o, 32'd0);

        drive(0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0);
        chk_en("ld_use_rs", 6'b000111);

        drive(0, 0, 0, 5'd0, 5'd5, 5'd0, 0, 0, 0);
        chk_en("post_stall", 6'b110101);
        chk("stall_after_1", stall_count_o, 32'd1);
        chk("cycle_after_2", cycle_count_o, 32'd2);

        drive(0, 0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        chk_en("rw_zero", 6'b110101);

        drive(0, 0, 1, 5'd5, 5'd1, 5'd5, 0, 0, 0);
        chk_en("rt_unused", 6'b110101);
        chk("stall_still_1", stall_count_o, 32'd1);

        drive(0, 0, 1, 5'd5, 5'd1, 5'd5, 1, 0, 0);
        chk_en("ld_use_rt", 6'b000111);

        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        chk_en("branch", 6'b111101);
        chk("stall_2", stall_count_o, 32'd2);

        drive(0, 0, 1, 5'd3, 5'd3, 5'd0, 0, 1, 0);
        chk_en("br_hazard", 6'b000111);

        for (int i = 0; i < 8; i++) begin
            logic s;
            s = (i == 1) || (i == 4);
            drive(1, s, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
            if (i == 0) begin
                chk("dbg_cycle_start", cycle_count_o, 32'd8);
                chk("dbg_stall_start", stall_count_o, 32'd3);
                chk("sat_cycle_8", {28'd0, s_cycle}, 32'd8);
            end
            chk_en($sformatf("step_%0d", i), s ? 6'b110101 : 6'b000000);
        end

        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
        chk("dbg_cycle_end", cycle_count_o, 32'd10);
        chk_en("halt_br", 6'b110101);
        chk("halt_state", {30'd0, state_o}, 32'd0);

        for (int d = 0; d < 3; d++) begin
            drive(0, 0, 1, 5'd5, 5'd5, 5'd5, 1, 1, 1);
            chk($sformatf("drain_state_%0d", d), {30'd0, state_o}, 32'd1);
            chk_en($sformatf("drain_en_%0d", d), 6'b000111);
            chk($sformatf("drain_halted_%0d", d), {31'd0, halted_o}, 32'd0);
        end

        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        chk("halted_state", {30'd0, state_o}, 32'd2);
        chk("halted_flag", {31'd0, halted_o}, 32'd1);
        chk_en("halted_en", 6'b000000);
        chk("halted_cycle", cycle_count_o, 32'd14);
        chk("halted_stall", stall_count_o, 32'd3);

        drive(1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        chk_en("halted_step_en", 6'b000000);
        chk("halted_step_state", {30'd0, state_o}, 32'd2);

        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        chk("halted_cycle_frozen", cycle_count_o, 32'd14);
        #1 reset_i = 1'b0;
        #1;
        chk("rst_halt_state", {30'd0, state_o}, 32'd0);
        chk("rst_halt_flag", {31'd0, halted_o}, 32'd0);
        #1 reset_i = 1'b1;

        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        chk_en("rerun_en", 6'b110101);
        chk("rerun_cycle", cycle_count_o, 32'd1);

        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        chk("drain2_state", {30'd0, state_o}, 32'd1);
        #1 reset_i = 1'b0;
        #1;
        chk_en("rst_drain_en", 6'b000000);
        chk("rst_drain_state", {30'd0, state_o}, 32'd0);
        chk("rst_drain_cycle", cycle_count_o, 32'd0);
        chk("rst_drain_stall", stall_count_o, 32'd0);
        #1 reset_i = 1'b1;

        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        chk("post_rst_state", {30'd0, state_o}, 32'd0);
        chk_en("post_rst_en", 6'b110101);
        chk("post_rst_cycle", cycle_count_o, 32'd1);
        chk("post_rst_stall", stall_count_o, 32'd0);

        chk("sat_cycle_15", {28'd0, s_cycle}, 32'd15);
        chk("sat_stall_0", {28'd0, s_stall}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pipeline_control_unit
`default_nettype wire
